// File: rtl/note_sequencer_pkg.sv
// Shared song-word format, note/beat constants and sequencer FSM encoding.
// Also imported by the tone generator and the table loaders.
package note_sequencer_pkg;

  localparam int unsigned NOTE_W    = 5;
  localparam int unsigned BEAT_W    = 4;
  localparam int unsigned DEPTH     = 256;
  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam int unsigned QTR_TICKS = 4;
  localparam int unsigned WORD_W    = 1 + BEAT_W + NOTE_W;
  localparam int unsigned CNT_W     = BEAT_W + $clog2(QTR_TICKS) + 1;

  // Bit offsets of the fields inside a {lig, beat, note} song word
  localparam int unsigned NOTE_LSB = 0;
  localparam int unsigned BEAT_LSB = NOTE_W;
  localparam int unsigned LIG_BIT  = NOTE_W + BEAT_W;

  localparam logic [NOTE_W-1:0] NOTE_NA = '0;

  // Beat durations in quarter-beat units; BEAT_4 needs BEAT_W >= 5
  localparam int unsigned BEAT_0_25 = 1;
  localparam int unsigned BEAT_0_5  = 2;
  localparam int unsigned BEAT_0_75 = 3;
  localparam int unsigned BEAT_1    = 4;
  localparam int unsigned BEAT_1_5  = 6;
  localparam int unsigned BEAT_2    = 8;
  localparam int unsigned BEAT_3    = 12;
  localparam int unsigned BEAT_4    = 16;

  typedef struct packed {
    logic              lig;
    logic [BEAT_W-1:0] beat;
    logic [NOTE_W-1:0] note;
  } song_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_PAUSED
  } seq_state_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Control, table-load and note-output bundle of the note sequencer.
interface note_sequencer_if;
  import note_sequencer_pkg::*;

  logic              tick;
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  song_word_t        wr_data;
  logic [NOTE_W-1:0] note;
  logic              note_valid;
  logic              note_start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] idx;

  modport master (
    output tick, start, stop, pause, loop_en, wr_en, wr_addr, wr_data,
    input  note, note_valid, note_start, busy, done, idx
  );

  modport slave (
    input  tick, start, stop, pause, loop_en, wr_en, wr_addr, wr_data,
    output note, note_valid, note_start, busy, done, idx
  );

endinterface

// File: rtl/note_table_ram.sv
// Song table: one write port, one synchronous read port; a same-cycle
// write/read of one address returns the old word. Contents are never reset.
module note_table_ram
  import note_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  song_word_t        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output song_word_t        rd_data
);

  song_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays {lig, beat, note} words from a RAM song table, holding each note for
// beat*QTR_TICKS tempo ticks, with start/stop/pause, loop/one-shot and ties.
module note_sequencer
  import note_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  note_sequencer_if.slave bus
);

  seq_state_t        state, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              tie, tie_next;
  logic [NOTE_W-1:0] note_reg, note_next;
  logic              valid_reg, valid_next;
  logic              onset_reg, onset_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  song_word_t        rd_word;

  // Reading at idx_next lets FETCH decode the new word on its first cycle
  note_table_ram u_table (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (idx_next),
    .rd_data (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx_reg   <= '0;
      cnt       <= '0;
      tie       <= 1'b0;
      note_reg  <= NOTE_NA;
      valid_reg <= 1'b0;
      onset_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state     <= state_next;
      idx_reg   <= idx_next;
      cnt       <= cnt_next;
      tie       <= tie_next;
      note_reg  <= note_next;
      valid_reg <= valid_next;
      onset_reg <= onset_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx_reg;
    cnt_next   = cnt;
    tie_next   = tie;
    note_next  = note_reg;
    valid_next = valid_reg;
    onset_next = 1'b0;
    done_next  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_FETCH;
          idx_next   = '0;
          tie_next   = 1'b0;
        end
      end
      ST_FETCH: begin
        if (rd_word.beat == '0) begin
          if (bus.loop_en) begin
            idx_next = '0;
          end else begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
            note_next  = NOTE_NA;
            valid_next = 1'b0;
          end
        end else begin
          state_next = ST_PLAY;
          note_next  = rd_word.note;
          cnt_next   = CNT_W'(CNT_W'(rd_word.beat) * CNT_W'(QTR_TICKS));
          valid_next = 1'b1;
          // A tied predecessor or a rest suppresses the onset pulse
          onset_next = (rd_word.note != NOTE_NA) && !tie;
          tie_next   = rd_word.lig;
        end
      end
      ST_PLAY: begin
        if (bus.pause) begin
          state_next = ST_PAUSED;
          valid_next = 1'b0;
        end else if (bus.tick) begin
          cnt_next = cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state_next = ST_FETCH;
            idx_next   = (idx_reg == ADDR_W'(DEPTH - 1)) ? '0 : idx_reg + 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        if (bus.start) begin
          state_next = ST_PLAY;
          valid_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (bus.stop) begin
      state_next = ST_IDLE;
      idx_next   = '0;
      cnt_next   = '0;
      tie_next   = 1'b0;
      note_next  = NOTE_NA;
      valid_next = 1'b0;
      onset_next = 1'b0;
      done_next  = 1'b0;
    end

    busy_next = (state_next != ST_IDLE);
  end

  assign bus.note       = note_reg;
  assign bus.note_valid = valid_reg;
  assign bus.note_start = onset_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.idx        = idx_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: one-shot, loop, tie, pause, stop, reset
// retention, live rewrite and full-table wrap, with per-cycle output statistics.
module tb_note_sequencer;
  import note_sequencer_pkg::*;

  localparam int G4 = 8;
  localparam int A4 = 10;
  localparam int C5 = 13;

  logic clk = 1'b0;
  logic rst;
  note_sequencer_if bus ();

  note_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  int note_cycles [32];
  int first_seen  [32];
  int start_cyc   [4];
  int n_start, n_done, done_cyc, n_gap;
  bit seen_nv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; n_start = 0; n_done = 0; done_cyc = -1; n_gap = 0; seen_nv = 1'b0;
    for (int i = 0; i < 32; i++) begin
      note_cycles[i] = 0;
      first_seen[i]  = -1;
    end
    for (int i = 0; i < 4; i++) start_cyc[i] = -1;
  endtask

  // One clock; outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.note_valid) begin
      note_cycles[bus.note]++;
      if (first_seen[bus.note] < 0) first_seen[bus.note] = cyc;
      seen_nv = 1'b1;
    end else if (bus.busy && seen_nv) begin
      n_gap++;
    end
    if (bus.note_start) begin
      if (n_start < 4) start_cyc[n_start] = cyc;
      n_start++;
    end
    if (bus.done) begin
      if (n_done == 0) done_cyc = cyc;
      n_done++;
    end
  endtask

  function automatic song_word_t mk_word(input int lig, input int beat, input int nt);
    logic [WORD_W-1:0] v;
    v = '0;
    v[LIG_BIT] = 1'(lig);
    v[BEAT_LSB +: BEAT_W] = BEAT_W'(beat);
    v[NOTE_LSB +: NOTE_W] = NOTE_W'(nt);
    return song_word_t'(v);
  endfunction

  task automatic write_word(input int addr, input int lig, input int beat, input int nt);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(addr);
    bus.wr_data = mk_word(lig, beat, nt);
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic load_basic();
    write_word(0, 0, BEAT_1, G4);
    write_word(1, 0, BEAT_0_5, A4);
    write_word(2, 0, 0, 0);
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_note"}, 32'(bus.note), 0);
    check({tag, "_valid"}, 32'(bus.note_valid), 0);
    check({tag, "_start"}, 32'(bus.note_start), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_idx"}, 32'(bus.idx), 0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.loop_en = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    clear_stats();
    repeat (3) step();
    check_all_idle("reset");
    rst = 1'b0;

    // One-shot: G4 for 16 ticks, A4 for 8, then done
    load_basic();
    bus.tick = 1'b1;
    clear_stats();
    pulse_start();
    repeat (35) step();
    check("oneshot_g4_cycles", 32'(note_cycles[G4]), 17);
    check("oneshot_a4_cycles", 32'(note_cycles[A4]), 9);
    check("oneshot_starts", 32'(n_start), 2);
    check("oneshot_first_onset", 32'(start_cyc[0]), 2);
    check("oneshot_a4_onset", 32'(start_cyc[1]), 19);
    check("oneshot_done_count", 32'(n_done), 1);
    check("oneshot_done_cyc", 32'(done_cyc), 28);
    check("oneshot_busy_end", 32'(bus.busy), 0);
    check("oneshot_valid_end", 32'(bus.note_valid), 0);

    // Loop: end marker costs one extra FETCH, no done, no dropout
    bus.loop_en = 1'b1;
    clear_stats();
    pulse_start();
    repeat (39) step();
    check("loop_g4_again", 32'(start_cyc[2]), 29);
    check("loop_a4_cycles", 32'(note_cycles[A4]), 10);
    check("loop_starts", 32'(n_start), 3);
    check("loop_no_done", 32'(n_done), 0);
    check("loop_no_gap", 32'(n_gap), 0);
    check("loop_busy", 32'(bus.busy), 1);
    pulse_stop();
    bus.loop_en = 1'b0;

    // Tie G4~G4 then a rest
    write_word(0, 1, BEAT_1, G4);
    write_word(1, 0, BEAT_1, G4);
    write_word(2, 0, BEAT_0_25, 0);
    write_word(3, 0, 0, 0);
    clear_stats();
    pulse_start();
    repeat (44) step();
    check("tie_starts", 32'(n_start), 1);
    check("tie_g4_cycles", 32'(note_cycles[G4]), 34);
    check("tie_rest_cycles", 32'(note_cycles[0]), 5);
    check("tie_no_gap", 32'(n_gap), 0);
    check("tie_done_cyc", 32'(done_cyc), 41);

    // Pause after 5 ticks of a 16-tick note, resume later
    load_basic();
    bus.tick = 1'b0;
    clear_stats();
    pulse_start();
    step();
    bus.tick = 1'b1;
    repeat (5) step();
    bus.tick = 1'b0;
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    check("pause_valid", 32'(bus.note_valid), 0);
    check("pause_note", 32'(bus.note), G4);
    check("pause_busy", 32'(bus.busy), 1);
    bus.tick = 1'b1;
    repeat (20) step();
    check("pause_idx_frozen", 32'(bus.idx), 0);
    check("pause_valid_held", 32'(bus.note_valid), 0);
    check("pause_gap_cycles", 32'(n_gap), 21);
    bus.tick = 1'b0;
    pulse_start();
    base = cyc;
    check("resume_valid", 32'(bus.note_valid), 1);
    check("resume_no_onset", 32'(bus.note_start), 0);
    bus.tick = 1'b1;
    repeat (14) step();
    check("resume_remaining", 32'(first_seen[A4] - base), 12);
    check("resume_starts", 32'(n_start), 2);
    pulse_stop();

    // stop and start together mid-note
    clear_stats();
    pulse_start();
    repeat (21) step();
    check("stop_pre_idx", 32'(bus.idx), 1);
    bus.stop = 1'b1;
    bus.start = 1'b1;
    step();
    bus.stop = 1'b0;
    bus.start = 1'b0;
    check_all_idle("stop");
    repeat (3) step();
    check("stop_stays_idle", 32'(bus.busy), 0);

    // Reset mid-PLAY keeps the table
    clear_stats();
    pulse_start();
    repeat (21) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_idle("rst_mid");
    clear_stats();
    pulse_start();
    repeat (20) step();
    check("retain_g4", 32'(first_seen[G4]), 2);
    check("retain_a4", 32'(first_seen[A4]), 19);
    pulse_stop();

    // Rewrite the sounding entry; change appears on the next pass
    bus.loop_en = 1'b1;
    clear_stats();
    pulse_start();
    repeat (4) step();
    write_word(0, 0, BEAT_1, C5);
    check("rewrite_held", 32'(bus.note), G4);
    repeat (30) step();
    check("rewrite_g4_cycles", 32'(note_cycles[G4]), 17);
    check("rewrite_c5_onset", 32'(first_seen[C5]), 29);
    check("rewrite_starts", 32'(n_start), 3);
    pulse_stop();
    bus.loop_en = 1'b0;

    // Full table of non-zero beats wraps at DEPTH-1 even in one-shot mode
    for (int i = 0; i < int'(DEPTH); i++) write_word(i, 0, BEAT_0_25, (i % 31) + 1);
    clear_stats();
    pulse_start();
    repeat (1284) step();
    check("wrap_no_done", 32'(n_done), 0);
    check("wrap_starts", 32'(n_start), 257);
    check("wrap_idx", 32'(bus.idx), 0);
    check("wrap_note", 32'(bus.note), 1);
    pulse_stop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
